etapa_id_exe: RTL and testbench
===============================

# etapa_id_exe

Decode, hazard-forwarding and execute datapath of the pipelined 32-bit vector processor used for byte-wise encrypt/decrypt kernels (xor, add, shift, circular shift). The block sits between the IF/ID and EXE/MEM pipeline registers. It consumes the IF/ID instruction word and write-back data, and produces operands and forwarding selects for the ID/EXE register. It also computes the ALU result from the ID/EXE register outputs. The register files are the only state; everything else is combinational.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock for register-file writes.
- reset  in  1  synchronous, active-high; clears both register files.
- instruccion  in  14  decoded instruction from IF/ID.
- reg_rdv, reg_rds  in  1  vector / scalar read enables from control unit.
- sel_dest  in  1  destination-field select.
- data_wrv  in  32  vector write-back data.
- data_wrs  in  8  scalar write-back data.
- i_dir_wr  in  3  write-back register address.
- reg_wrv, reg_wrs  in  1  vector / scalar write enables (from MEM/WB).
- opcode  out  4  instruccion[13:10].
- shift  out  8  {5'b0, instruccion[2:0]}.
- inmediato  out  8  instruccion[7:0].
- dir_dest_out  out  3  destination address.
- data_vec1, data_vec2  out  32  vector operands.
- data_sca1  out  8  scalar operand.
- VFS  out  32  scalar replicated to four byte lanes.
- sel_ad  in  1  forwarding enable from control unit.
- dir_dest_EXE  in  3  destination of the instruction one stage ahead.
- sel_vec  out  2  forwarding select, to be registered into ID/EXE.
- exe_sel_int, exe_sel_op  in  1  registered operand selects.
- exe_opcode  in  4  registered ALU opcode.
- exe_vector_a, exe_vector_b, exe_vfs, vector_ad  in  32  registered operands; vector_ad is write-back forwarding data.
- exe_out_s, exe_shamt  in  8  registered scalar / shift amount.
- exe_sel_vec  in  2  registered forwarding select.
- exe_dir_dest_in  in  3  registered destination.
- exe_inmediate_in  in  8  registered immediate.
- alu_result  out  32  ALU result.
- data1_out  out  32  operand A after forwarding (store data).
- exe_dir_dest_out  out  3  pass-through of exe_dir_dest_in.
- inmediate_out  out  8  pass-through of exe_inmediate_in.

## Operation
- Instruction fields: rd=[9:7], rs1=[6:4], rs2=[3:1].
- Register files:
  - 8 x 32-bit vector registers (vreg).
  - 8 x 8-bit scalar registers (sreg).
  - No hardwired-zero register.
- Reads:
  - data_vec1 = vreg[rs1] and data_vec2 = vreg[rs2] when reg_rdv=1, else 0.
  - data_sca1 = sreg[rs2] when reg_rds=1, else 0.
  - VFS = {4{data_sca1}}.
  - Read bypass: if the same-cycle write targets the read address with its enable set, the read returns the write data.
- dir_dest_out = sel_dest ? rs1 : rd.
- Forwarding (sel_vec):
  - bit0 = sel_ad & (dir_dest_EXE == dir_dest_out).
  - bit1 = sel_ad & (dir_dest_EXE == rs2).
- EXE operand selection:
  - A = exe_sel_vec[0] ? vector_ad : exe_vector_a.
  - Bv = exe_sel_vec[1] ? vector_ad : exe_vector_b.
  - B = exe_sel_int ? exe_vfs : Bv.
  - Shift amount n = (exe_sel_op ? exe_shamt : exe_out_s)[2:0].
- ALU: every operation is applied independently to each of the 4 byte lanes; no carry crosses a lane.
  - 0000 pass A.
  - 0001 A^B.
  - 0010 A+B mod 256.
  - 0011 A-B mod 256.
  - 0100 A<<n.
  - 0101 A>>n (logical).
  - 0110 rotate-left A by n.
  - 0111 rotate-right A by n.
  - 1000-1111 result 0.
- data1_out = A.

## Timing
- Register-file writes occur on the rising edge of clk:
  - vreg[i_dir_wr] <= data_wrv when reg_wrv=1.
  - sreg[i_dir_wr] <= data_wrs when reg_wrs=1.
  - Both may write in the same cycle.
- reset=1 at an edge clears all 16 registers and overrides any simultaneous write. After reset, every read output is 0.
- All other outputs are combinational with zero latency; there are no output registers and no handshake.
- sel_vec is valid in the same cycle as the ID inputs.
- The EXE section depends only on its exe_* inputs and vector_ad.

## Test plan
- Reset, then read all addresses with reg_rdv=reg_rds=1 -> data_vec1, data_vec2, data_sca1, VFS all 0.
- Write vreg[3]=32'hA1B2C3D4 and sreg[5]=8'h7E; read with rs1=3, rs2=5 -> data_vec1=A1B2C3D4, data_sca1=7E, VFS=7E7E7E7E.
- Read/write bypass: same-cycle write to vreg[2]=32'h12345678 with rs1=2 -> data_vec1=12345678 before the edge.
- Forwarding: sel_ad=1, dir_dest_EXE=4, rd=4, sel_dest=0, rs2=4 -> sel_vec=11. With sel_ad=0 -> sel_vec=00.
- ALU lanes, A=32'hFF01_8010:
  - B=32'h0101_0101, op 0010 -> 00028111.
  - n=1, op 0110 -> FF020120.
  - n=1, op 0100 -> FE020020.
  - op 0001 with exe_sel_int=1, exe_vfs=32'hFFFF_FFFF -> 00FE7FEF.
- EXE forwarding: exe_sel_vec=01, vector_ad=32'h11111111, op 0000 -> alu_result=data1_out=11111111; pass-throughs equal their inputs.

Source files
------------

// File: rtl/etapa_id_exe.sv
// etapa_id_exe: ID register files, operand forwarding selects and byte-lane EXE ALU
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high clear of both register files
//   instruccion             IF/ID word: op[13:10] rd[9:7] rs1[6:4] rs2[3:1]
//   reg_rdv/reg_rds         vector/scalar read enables; sel_dest picks rs1 (1) or rd (0) as destination
//   data_wrv/data_wrs       write-back data; i_dir_wr address; reg_wrv/reg_wrs write enables
//   opcode/shift/inmediato  decoded fields; dir_dest_out destination; data_vec1/2, data_sca1, VFS operands
//   sel_ad, dir_dest_EXE    forwarding enable and EXE destination -> sel_vec
//   exe_*, vector_ad        registered EXE inputs -> alu_result, data1_out and pass-throughs
module etapa_id_exe (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] instruccion,
    input  logic        reg_rdv,
    input  logic        reg_rds,
    input  logic        sel_dest,
    input  logic [31:0] data_wrv,
    input  logic [7:0]  data_wrs,
    input  logic [2:0]  i_dir_wr,
    input  logic        reg_wrv,
    input  logic        reg_wrs,
    output logic [3:0]  opcode,
    output logic [7:0]  shift,
    output logic [7:0]  inmediato,
    output logic [2:0]  dir_dest_out,
    output logic [31:0] data_vec1,
    output logic [31:0] data_vec2,
    output logic [7:0]  data_sca1,
    output logic [31:0] VFS,
    input  logic        sel_ad,
    input  logic [2:0]  dir_dest_EXE,
    output logic [1:0]  sel_vec,
    input  logic        exe_sel_int,
    input  logic        exe_sel_op,
    input  logic [3:0]  exe_opcode,
    input  logic [31:0] exe_vector_a,
    input  logic [31:0] exe_vector_b,
    input  logic [31:0] exe_vfs,
    input  logic [31:0] vector_ad,
    input  logic [7:0]  exe_out_s,
    input  logic [7:0]  exe_shamt,
    input  logic [1:0]  exe_sel_vec,
    input  logic [2:0]  exe_dir_dest_in,
    input  logic [7:0]  exe_inmediate_in,
    output logic [31:0] alu_result,
    output logic [31:0] data1_out,
    output logic [2:0]  exe_dir_dest_out,
    output logic [7:0]  inmediate_out
);
    logic [31:0] vreg [8];
    logic [7:0]  sreg [8];
    logic [2:0]  rd, rs1, rs2, n;
    logic [31:0] a_op, bv, b_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                vreg[i] <= '0;
                sreg[i] <= '0;
            end
        end else begin
            if (reg_wrv) vreg[i_dir_wr] <= data_wrv;
            if (reg_wrs) sreg[i_dir_wr] <= data_wrs;
        end
    end

    assign rd  = instruccion[9:7];
    assign rs1 = instruccion[6:4];
    assign rs2 = instruccion[3:1];

    assign opcode       = instruccion[13:10];
    assign shift        = {5'b0, instruccion[2:0]};
    assign inmediato    = instruccion[7:0];
    assign dir_dest_out = sel_dest ? rs1 : rd;

    // Reads see a same-cycle write to the same address so write-back needs no extra stall.
    assign data_vec1 = !reg_rdv ? '0 : (reg_wrv && i_dir_wr == rs1) ? data_wrv : vreg[rs1];
    assign data_vec2 = !reg_rdv ? '0 : (reg_wrv && i_dir_wr == rs2) ? data_wrv : vreg[rs2];
    assign data_sca1 = !reg_rds ? '0 : (reg_wrs && i_dir_wr == rs2) ? data_wrs : sreg[rs2];
    assign VFS       = {4{data_sca1}};

    assign sel_vec = {sel_ad && dir_dest_EXE == rs2, sel_ad && dir_dest_EXE == dir_dest_out};

    assign a_op = exe_sel_vec[0] ? vector_ad : exe_vector_a;
    assign bv   = exe_sel_vec[1] ? vector_ad : exe_vector_b;
    assign b_op = exe_sel_int ? exe_vfs : bv;
    assign n    = exe_sel_op ? exe_shamt[2:0] : exe_out_s[2:0];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            logic [7:0]  a, b;
            logic [15:0] dl, dr;
            assign a  = a_op[8*g +: 8];
            assign b  = b_op[8*g +: 8];
            // Rotations shift a doubled copy of the byte so the wrapped bits fall into the kept half.
            assign dl = {a, a} << n;
            assign dr = {a, a} >> n;
            assign alu_result[8*g +: 8] = exe_opcode == 4'b0000 ? a :
                                          exe_opcode == 4'b0001 ? a ^ b :
                                          exe_opcode == 4'b0010 ? a + b :
                                          exe_opcode == 4'b0011 ? a - b :
                                          exe_opcode == 4'b0100 ? a << n :
                                          exe_opcode == 4'b0101 ? a >> n :
                                          exe_opcode == 4'b0110 ? dl[15:8] :
                                          exe_opcode == 4'b0111 ? dr[7:0] : 8'h00;
        end
    endgenerate

    assign data1_out        = a_op;
    assign exe_dir_dest_out = exe_dir_dest_in;
    assign inmediate_out    = exe_inmediate_in;
endmodule

// File: tb/tb_etapa_id_exe.sv
// tb_etapa_id_exe: directed and randomized checks of register files, forwarding selects and byte-lane ALU
module tb_etapa_id_exe;
    logic        clk = 0;
    logic        reset;
    logic [13:0] instruccion;
    logic        reg_rdv, reg_rds, sel_dest;
    logic [31:0] data_wrv;
    logic [7:0]  data_wrs;
    logic [2:0]  i_dir_wr;
    logic        reg_wrv, reg_wrs;
    logic [3:0]  opcode;
    logic [7:0]  shift, inmediato;
    logic [2:0]  dir_dest_out;
    logic [31:0] data_vec1, data_vec2, VFS;
    logic [7:0]  data_sca1;
    logic        sel_ad;
    logic [2:0]  dir_dest_EXE;
    logic [1:0]  sel_vec;
    logic        exe_sel_int, exe_sel_op;
    logic [3:0]  exe_opcode;
    logic [31:0] exe_vector_a, exe_vector_b, exe_vfs, vector_ad;
    logic [7:0]  exe_out_s, exe_shamt;
    logic [1:0]  exe_sel_vec;
    logic [2:0]  exe_dir_dest_in;
    logic [7:0]  exe_inmediate_in;
    logic [31:0] alu_result, data1_out;
    logic [2:0]  exe_dir_dest_out;
    logic [7:0]  inmediate_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] mv [8];
    logic [7:0]  ms [8];

    etapa_id_exe dut (
        .clk(clk), .reset(reset), .instruccion(instruccion), .reg_rdv(reg_rdv), .reg_rds(reg_rds),
        .sel_dest(sel_dest), .data_wrv(data_wrv), .data_wrs(data_wrs), .i_dir_wr(i_dir_wr),
        .reg_wrv(reg_wrv), .reg_wrs(reg_wrs), .opcode(opcode), .shift(shift), .inmediato(inmediato),
        .dir_dest_out(dir_dest_out), .data_vec1(data_vec1), .data_vec2(data_vec2), .data_sca1(data_sca1),
        .VFS(VFS), .sel_ad(sel_ad), .dir_dest_EXE(dir_dest_EXE), .sel_vec(sel_vec),
        .exe_sel_int(exe_sel_int), .exe_sel_op(exe_sel_op), .exe_opcode(exe_opcode),
        .exe_vector_a(exe_vector_a), .exe_vector_b(exe_vector_b), .exe_vfs(exe_vfs), .vector_ad(vector_ad),
        .exe_out_s(exe_out_s), .exe_shamt(exe_shamt), .exe_sel_vec(exe_sel_vec),
        .exe_dir_dest_in(exe_dir_dest_in), .exe_inmediate_in(exe_inmediate_in), .alu_result(alu_result),
        .data1_out(data1_out), .exe_dir_dest_out(exe_dir_dest_out), .inmediate_out(inmediate_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] mk(input int op, input int rd, input int rs1, input int rs2, input int b0);
        return 14'((op << 10) | (rd << 7) | (rs1 << 4) | (rs2 << 1) | b0);
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b, input int n);
        logic [31:0] r = 0;
        for (int l = 0; l < 4; l++) begin
            int x, y, z;
            x = int'(a[8*l +: 8]);
            y = int'(b[8*l +: 8]);
            case (op)
                0: z = x;
                1: z = x ^ y;
                2: z = (x + y) % 256;
                3: z = (x - y + 256) % 256;
                4: z = (x * (1 << n)) % 256;
                5: z = x / (1 << n);
                6: z = ((x << n) | (x >> (8 - n))) & 255;
                7: z = ((x >> n) | (x << (8 - n))) & 255;
                default: z = 0;
            endcase
            r[8*l +: 8] = 8'(z);
        end
        return r;
    endfunction

    task automatic wr(input logic v, input logic s, input logic [2:0] ad, input logic [31:0] dv, input logic [7:0] ds);
        @(negedge clk);
        reg_wrv = v; reg_wrs = s; i_dir_wr = ad; data_wrv = dv; data_wrs = ds;
        @(posedge clk);
        #1;
        if (v) mv[ad] = dv;
        if (s) ms[ad] = ds;
        reg_wrv = 0; reg_wrs = 0;
    endtask

    task automatic chk_reads(input string tag);
        logic [31:0] e1, e2;
        logic [7:0]  es;
        e1 = (reg_wrv && i_dir_wr == instruccion[6:4]) ? data_wrv : mv[instruccion[6:4]];
        e2 = (reg_wrv && i_dir_wr == instruccion[3:1]) ? data_wrv : mv[instruccion[3:1]];
        es = (reg_wrs && i_dir_wr == instruccion[3:1]) ? data_wrs : ms[instruccion[3:1]];
        if (!reg_rdv) begin e1 = 0; e2 = 0; end
        if (!reg_rds) es = 0;
        chk({tag, "_vec1"}, data_vec1, e1);
        chk({tag, "_vec2"}, data_vec2, e2);
        chk({tag, "_sca1"}, {24'b0, data_sca1}, {24'b0, es});
        chk({tag, "_vfs"}, VFS, {es, es, es, es});
    endtask

    task automatic chk_exe(input string tag);
        logic [31:0] a, b;
        int n;
        a = exe_sel_vec[0] ? vector_ad : exe_vector_a;
        b = exe_sel_int ? exe_vfs : (exe_sel_vec[1] ? vector_ad : exe_vector_b);
        n = exe_sel_op ? int'(exe_shamt) % 8 : int'(exe_out_s) % 8;
        chk({tag, "_alu"}, alu_result, alu_ref(int'(exe_opcode), a, b, n));
        chk({tag, "_d1"}, data1_out, a);
        chk({tag, "_dst"}, {29'b0, exe_dir_dest_out}, {29'b0, exe_dir_dest_in});
        chk({tag, "_imm"}, {24'b0, inmediate_out}, {24'b0, exe_inmediate_in});
    endtask

    initial begin
        reset = 1; instruccion = 0; reg_rdv = 0; reg_rds = 0; sel_dest = 0;
        data_wrv = 32'hDEADBEEF; data_wrs = 8'h5A; i_dir_wr = 3; reg_wrv = 1; reg_wrs = 1;
        sel_ad = 0; dir_dest_EXE = 0; exe_sel_int = 0; exe_sel_op = 0; exe_opcode = 0;
        exe_vector_a = 0; exe_vector_b = 0; exe_vfs = 0; vector_ad = 0; exe_out_s = 0; exe_shamt = 0;
        exe_sel_vec = 0; exe_dir_dest_in = 0; exe_inmediate_in = 0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; ms[i] = 0; end
        // writes presented during reset must be dropped
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0; reg_wrv = 0; reg_wrs = 0;
        reg_rdv = 1; reg_rds = 1;
        for (int i = 0; i < 8; i++) begin
            instruccion = mk(0, 0, i, i, 0);
            #1 chk_reads("rst");
        end

        wr(1, 0, 3, 32'hA1B2C3D4, 0);
        wr(0, 1, 5, 0, 8'h7E);
        instruccion = mk(0, 0, 3, 5, 0);
        #1;
        chk("dir_vec1", data_vec1, 32'hA1B2C3D4);
        chk("dir_sca1", {24'b0, data_sca1}, 32'h7E);
        chk("dir_vfs", VFS, 32'h7E7E7E7E);

        @(negedge clk);
        reg_wrv = 1; i_dir_wr = 2; data_wrv = 32'h12345678;
        instruccion = mk(0, 0, 2, 0, 0);
        #1 chk("bypass_vec1", data_vec1, 32'h12345678);
        @(posedge clk);
        #1 mv[2] = 32'h12345678; reg_wrv = 0;
        chk("after_wr_vec1", data_vec1, 32'h12345678);

        instruccion = mk(0, 4, 1, 4, 0); sel_dest = 0; sel_ad = 1; dir_dest_EXE = 4;
        #1 chk("fwd_on", {30'b0, sel_vec}, 32'd3);
        sel_ad = 0;
        #1 chk("fwd_off", {30'b0, sel_vec}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            wr(1'($urandom), 1'($urandom), 3'($urandom), $urandom, 8'($urandom));
            @(negedge clk);
            reg_wrv = 1'($urandom); reg_wrs = 1'($urandom); i_dir_wr = 3'($urandom);
            data_wrv = $urandom; data_wrs = 8'($urandom);
            reg_rdv = ($urandom_range(3) != 0); reg_rds = ($urandom_range(3) != 0);
            instruccion = 14'($urandom); sel_dest = 1'($urandom);
            sel_ad = 1'($urandom); dir_dest_EXE = 3'($urandom);
            #1;
            chk_reads("rnd");
            begin
                int d;
                d = sel_dest ? int'(instruccion[6:4]) : int'(instruccion[9:7]);
                chk("rnd_dest", {29'b0, dir_dest_out}, 32'(d));
                chk("rnd_selvec", {30'b0, sel_vec},
                    32'((sel_ad && int'(dir_dest_EXE) == int'(instruccion[3:1])) * 2 + (sel_ad && int'(dir_dest_EXE) == d)));
                chk("rnd_op", {28'b0, opcode}, 32'(int'(instruccion) / 1024));
                chk("rnd_shift", {24'b0, shift}, 32'(int'(instruccion) % 8));
                chk("rnd_imm", {24'b0, inmediato}, 32'(int'(instruccion) % 256));
            end
            @(posedge clk);
            #1;
            if (reg_wrv) mv[i_dir_wr] = data_wrv;
            if (reg_wrs) ms[i_dir_wr] = data_wrs;
            reg_wrv = 0; reg_wrs = 0;
        end

        exe_vector_a = 32'hFF01_8010; exe_vector_b = 32'h0101_0101; exe_sel_vec = 0;
        exe_sel_op = 1; exe_shamt = 1; exe_out_s = 8'h03;
        exe_opcode = 4'b0010;
        #1 chk("alu_add", alu_result, 32'h00028111);
        exe_opcode = 4'b0110;
        #1 chk("alu_rol", alu_result, 32'hFF020120);
        exe_opcode = 4'b0100;
        #1 chk("alu_shl", alu_result, 32'hFE020020);
        exe_opcode = 4'b0001; exe_sel_int = 1; exe_vfs = 32'hFFFF_FFFF;
        #1 chk("alu_xor_vfs", alu_result, 32'h00FE7FEF);
        exe_opcode = 4'b0000; exe_sel_int = 0; exe_sel_vec = 2'b01; vector_ad = 32'h11111111;
        exe_dir_dest_in = 6; exe_inmediate_in = 8'hC3;
        #1;
        chk("exe_fwd_alu", alu_result, 32'h11111111);
        chk("exe_fwd_d1", data1_out, 32'h11111111);
        chk("exe_pt_dst", {29'b0, exe_dir_dest_out}, 32'd6);
        chk("exe_pt_imm", {24'b0, inmediate_out}, 32'hC3);

        for (int k = 0; k < 200; k++) begin
            exe_opcode = 4'($urandom); exe_vector_a = $urandom; exe_vector_b = $urandom;
            exe_vfs = $urandom; vector_ad = $urandom; exe_sel_vec = 2'($urandom);
            exe_sel_int = 1'($urandom); exe_sel_op = 1'($urandom);
            exe_out_s = 8'($urandom); exe_shamt = 8'($urandom);
            exe_dir_dest_in = 3'($urandom); exe_inmediate_in = 8'($urandom);
            #1 chk_exe("rnd_exe");
        end

        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; ms[i] = 0; end
        reg_rdv = 1; reg_rds = 1;
        for (int i = 0; i < 8; i++) begin
            instruccion = mk(0, 0, i, 7 - i, 0);
            #1 chk_reads("rst2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
